// File: rtl/hz_pkg.sv
// Shared types for the pipeline hazard unit: scoreboard entry, control FSM states
// and the forwarding-select width helper.
package hz_pkg;

  // Widest register index the scoreboard entry can hold; narrower indices are zero-extended.
  localparam int REG_AW_MAX = 8;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] rd;
    logic                  wr;
    logic                  load;
  } sb_entry_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} hz_state_e;

  function automatic int sel_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_fwd_pick.sv
// Priority search of the scoreboard for one source operand: youngest producer wins,
// and reports whether that producer's result is not yet forwardable.
module fwd_pick
  import hz_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 2,
  parameter int ZERO_REG = 1,
  parameter int SEL_W    = sel_width(STAGES)
) (
  input  sb_entry_t         sb [1:STAGES],
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_en,
  output logic [SEL_W-1:0]  sel,
  output logic              not_ready
);

  logic src_live;

  // Scan oldest to youngest so the last hit (smallest stage number) is kept.
  always_comb begin
    sel       = '0;
    not_ready = 1'b0;
    src_live  = rs_en && !((ZERO_REG != 0) && (rs == '0));
    for (int k = STAGES; k >= 1; k--) begin
      if (src_live && sb[k].valid && sb[k].wr && (sb[k].rd == REG_AW_MAX'(rs))) begin
        sel       = SEL_W'(k);
        not_ready = sb[k].load && (k < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Scoreboard-based hazard, forwarding and halt-drain controller sitting beside decode.
// Tracks in-flight instructions through STAGES downstream stages.
module pipe_hazard_unit
  import hz_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 2,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dec_valid,
  input  logic [REG_AW-1:0]             dec_rs1,
  input  logic                          dec_rs1_en,
  input  logic [REG_AW-1:0]             dec_rs2,
  input  logic                          dec_rs2_en,
  input  logic [REG_AW-1:0]             dec_rd,
  input  logic                          dec_wr,
  input  logic                          dec_load,
  input  logic                          dec_halt,
  input  logic                          flush,
  output logic                          stall,
  output logic                          bubble,
  output logic [sel_width(STAGES)-1:0]  fwd_a,
  output logic [sel_width(STAGES)-1:0]  fwd_b,
  output logic                          draining,
  output logic                          halted,
  output logic [CNT_W-1:0]              stall_cnt
);

  localparam int SEL_W = sel_width(STAGES);

  sb_entry_t        sb [1:STAGES];
  hz_state_e        state;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             nr_a, nr_b;
  logic             run, stall_int, issue, older_busy;

  fwd_pick #(.REG_AW(REG_AW), .STAGES(STAGES), .LOAD_LAT(LOAD_LAT), .ZERO_REG(ZERO_REG), .SEL_W(SEL_W))
    u_pick_a (.sb(sb), .rs(dec_rs1), .rs_en(dec_rs1_en), .sel(sel_a), .not_ready(nr_a));

  fwd_pick #(.REG_AW(REG_AW), .STAGES(STAGES), .LOAD_LAT(LOAD_LAT), .ZERO_REG(ZERO_REG), .SEL_W(SEL_W))
    u_pick_b (.sb(sb), .rs(dec_rs2), .rs_en(dec_rs2_en), .sel(sel_b), .not_ready(nr_b));

  // Outputs are gated by rst so the pipe sees a clean bubble while reset is held.
  assign run       = rst && (state == RUN);
  assign stall_int = run && dec_valid && !flush && (nr_a || nr_b);
  assign issue     = run && dec_valid && !flush && !stall_int;
  assign stall     = stall_int;
  assign bubble    = !issue;
  assign fwd_a     = (rst && (state != HALTED)) ? sel_a : '0;
  assign fwd_b     = (rst && (state != HALTED)) ? sel_b : '0;
  assign draining  = rst && (state == DRAIN);
  assign halted    = rst && (state == HALTED);

  // Anything that will still be in the scoreboard after the next shift.
  always_comb begin
    older_busy = 1'b0;
    for (int k = 1; k < STAGES; k++) older_busy = older_busy | sb[k].valid;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 1; k <= STAGES; k++) sb[k] <= '0;
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      if (state != HALTED) begin
        for (int k = STAGES; k >= 2; k--) sb[k] <= sb[k-1];
        sb[1] <= issue ? sb_entry_t'{valid: 1'b1, rd: REG_AW_MAX'(dec_rd), wr: dec_wr, load: dec_load}
                       : '0;
      end
      if (stall_int && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      case (state)
        RUN:     if (issue && dec_halt) state <= DRAIN;
        DRAIN:   if (!older_busy) state <= HALTED;
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Table-driven bench for pipe_hazard_unit (STAGES=3, LOAD_LAT=2); a second instance
// with ZERO_REG=0 shares the stimulus to expose register-0 forwarding.
module tb_pipe_hazard_unit;

  logic        clk = 1'b0;
  logic        rst, dec_valid, dec_rs1_en, dec_rs2_en, dec_wr, dec_load, dec_halt, flush;
  logic [3:0]  dec_rs1, dec_rs2, dec_rd;
  logic        stall, bubble, draining, halted;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;
  logic        z_stall, z_bubble, z_draining, z_halted;
  logic [1:0]  z_fwd_a, z_fwd_b;
  logic [15:0] z_stall_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.REG_AW(4), .STAGES(3), .LOAD_LAT(2), .ZERO_REG(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs1_en(dec_rs1_en),
    .dec_rs2(dec_rs2), .dec_rs2_en(dec_rs2_en), .dec_rd(dec_rd), .dec_wr(dec_wr),
    .dec_load(dec_load), .dec_halt(dec_halt), .flush(flush), .stall(stall), .bubble(bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .draining(draining), .halted(halted), .stall_cnt(stall_cnt));

  pipe_hazard_unit #(.REG_AW(4), .STAGES(3), .LOAD_LAT(2), .ZERO_REG(0), .CNT_W(16)) dut_z0 (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs1_en(dec_rs1_en),
    .dec_rs2(dec_rs2), .dec_rs2_en(dec_rs2_en), .dec_rd(dec_rd), .dec_wr(dec_wr),
    .dec_load(dec_load), .dec_halt(dec_halt), .flush(flush), .stall(z_stall), .bubble(z_bubble),
    .fwd_a(z_fwd_a), .fwd_b(z_fwd_b), .draining(z_draining), .halted(z_halted),
    .stall_cnt(z_stall_cnt));

  typedef struct {
    logic        rst, valid;
    logic [3:0]  rs1;
    logic        rs1_en;
    logic [3:0]  rs2;
    logic        rs2_en;
    logic [3:0]  rd;
    logic        wr, load, halt, flush;
    logic        e_stall, e_bubble;
    logic [1:0]  e_fa, e_fb;
    logic        e_dr, e_ht;
    logic [15:0] e_cnt;
    logic [1:0]  e_fa0;
  } vec_t;

  vec_t main_tbl[$];
  vec_t rst_tbl[$];
  vec_t exp_q[$];

  function automatic vec_t mk(int r, int v, int rs1, int e1, int rs2, int e2, int rd, int wr,
                              int ld, int ht, int fl, int st, int bu, int fa, int fb, int dr,
                              int hl, int cnt, int fa0);
    vec_t x;
    x.rst = 1'(r); x.valid = 1'(v); x.rs1 = 4'(rs1); x.rs1_en = 1'(e1);
    x.rs2 = 4'(rs2); x.rs2_en = 1'(e2); x.rd = 4'(rd); x.wr = 1'(wr);
    x.load = 1'(ld); x.halt = 1'(ht); x.flush = 1'(fl);
    x.e_stall = 1'(st); x.e_bubble = 1'(bu); x.e_fa = 2'(fa); x.e_fb = 2'(fb);
    x.e_dr = 1'(dr); x.e_ht = 1'(hl); x.e_cnt = 16'(cnt); x.e_fa0 = 2'(fa0);
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst        = v.rst;
    dec_valid  = v.valid;
    dec_rs1    = v.rs1;
    dec_rs1_en = v.rs1_en;
    dec_rs2    = v.rs2;
    dec_rs2_en = v.rs2_en;
    dec_rd     = v.rd;
    dec_wr     = v.wr;
    dec_load   = v.load;
    dec_halt   = v.halt;
    flush      = v.flush;
    exp_q.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t e;
    e = exp_q.pop_front();
    chk("stall",     int'(stall),     int'(e.e_stall));
    chk("bubble",    int'(bubble),    int'(e.e_bubble));
    chk("fwd_a",     int'(fwd_a),     int'(e.e_fa));
    chk("fwd_b",     int'(fwd_b),     int'(e.e_fb));
    chk("draining",  int'(draining),  int'(e.e_dr));
    chk("halted",    int'(halted),    int'(e.e_ht));
    chk("stall_cnt", int'(stall_cnt), int'(e.e_cnt));
    chk("fwd_a_z0",  int'(z_fwd_a),   int'(e.e_fa0));
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    // Columns: rst valid rs1 en1 rs2 en2 rd wr ld halt flush | stall bubble fa fb drain halted cnt fa_z0
    main_tbl.push_back(mk(1,1, 0,0, 0,0,  3,1,0,0,0,  0,0,0,0,0,0,0,0)); // ADD r3
    main_tbl.push_back(mk(1,1, 3,1, 0,0,  6,1,0,0,0,  0,0,1,0,0,0,0,1)); // SUB reads r3
    main_tbl.push_back(mk(1,1, 3,1, 0,0,  7,1,0,0,0,  0,0,2,0,0,0,0,2));
    main_tbl.push_back(mk(1,1, 3,1, 6,1,  0,0,0,0,0,  0,0,3,2,0,0,0,3));
    main_tbl.push_back(mk(1,1, 0,0, 0,0,  5,1,1,0,0,  0,0,0,0,0,0,0,0)); // LOAD r5
    main_tbl.push_back(mk(1,1, 0,0, 5,1,  8,1,0,0,0,  1,1,0,1,0,0,0,0)); // load-use stall
    main_tbl.push_back(mk(1,1, 0,0, 5,1,  8,1,0,0,0,  0,0,0,2,0,0,1,0));
    main_tbl.push_back(mk(1,1, 0,0, 0,0,  4,1,0,0,0,  0,0,0,0,0,0,1,0)); // two writers of r4
    main_tbl.push_back(mk(1,1, 0,0, 0,0,  4,1,0,0,0,  0,0,0,0,0,0,1,0));
    main_tbl.push_back(mk(1,1, 4,1, 4,0,  9,1,0,0,0,  0,0,1,0,0,0,1,1));
    main_tbl.push_back(mk(1,1, 4,1, 0,0,  0,0,0,0,0,  0,0,2,0,0,0,1,2));
    main_tbl.push_back(mk(1,1, 0,0, 0,0,  0,1,0,0,0,  0,0,0,0,0,0,1,0)); // writer of r0
    main_tbl.push_back(mk(1,1, 0,1, 0,0,  0,0,0,0,0,  0,0,0,0,0,0,1,1));
    main_tbl.push_back(mk(1,1, 0,0, 0,0,  2,1,1,0,0,  0,0,0,0,0,0,1,0)); // LOAD r2
    main_tbl.push_back(mk(1,1, 2,1, 0,0, 11,1,0,0,1,  0,1,1,0,0,0,1,1)); // flushed load-use
    main_tbl.push_back(mk(1,1, 2,1, 0,0, 10,1,0,0,0,  0,0,2,0,0,0,1,2));
    main_tbl.push_back(mk(1,1, 2,1,11,1,  0,0,0,0,0,  0,0,3,0,0,0,1,3)); // r11 never issued
    main_tbl.push_back(mk(1,1, 0,0, 0,0, 12,1,0,0,0,  0,0,0,0,0,0,1,0));
    main_tbl.push_back(mk(1,1, 0,0, 0,0, 13,1,0,0,0,  0,0,0,0,0,0,1,0));
    main_tbl.push_back(mk(1,1, 0,0, 0,0,  0,0,0,1,0,  0,0,0,0,0,0,1,0)); // HALT
    main_tbl.push_back(mk(1,1,13,1, 0,0,  0,0,0,0,0,  0,1,2,0,1,0,1,2));
    main_tbl.push_back(mk(1,1,13,1, 0,0,  0,0,0,0,0,  0,1,3,0,1,0,1,3));
    main_tbl.push_back(mk(1,1,13,1, 0,0,  0,0,0,0,0,  0,1,0,0,1,0,1,0));
    main_tbl.push_back(mk(1,1,13,1, 0,0,  5,1,1,0,0,  0,1,0,0,0,1,1,0)); // halted, inputs ignored
    main_tbl.push_back(mk(1,1, 0,0, 5,1,  6,1,0,0,0,  0,1,0,0,0,1,1,0));

    rst_tbl.push_back(mk(0,1, 3,1, 0,0,  3,1,0,0,0,  0,1,0,0,0,0,1,0)); // reset out of HALTED
    rst_tbl.push_back(mk(1,1, 0,0, 0,0,  3,1,0,0,0,  0,0,0,0,0,0,0,0));
    rst_tbl.push_back(mk(1,1, 0,0, 0,0,  0,0,0,1,0,  0,0,0,0,0,0,0,0)); // HALT
    rst_tbl.push_back(mk(1,1, 3,1, 0,0,  0,0,0,0,0,  0,1,2,0,1,0,0,2));
    rst_tbl.push_back(mk(0,1, 3,1, 0,0,  0,0,0,0,0,  0,1,0,0,0,0,0,0)); // reset mid-DRAIN
    rst_tbl.push_back(mk(1,1, 3,1, 0,0,  3,1,0,0,0,  0,0,0,0,0,0,0,0));
    rst_tbl.push_back(mk(1,1, 3,1, 0,0,  0,0,0,0,0,  0,0,1,0,0,0,0,1));
    rst_tbl.push_back(mk(1,1, 0,0, 0,0,  7,1,1,0,0,  0,0,0,0,0,0,0,0)); // LOAD r7
    rst_tbl.push_back(mk(1,1, 7,1, 0,0,  0,0,0,0,0,  1,1,1,0,0,0,0,1));
    rst_tbl.push_back(mk(1,1, 7,1, 0,0,  0,0,0,0,0,  0,0,2,0,0,0,1,2));

    rst = 1'b0; dec_valid = 1'b0; dec_rs1 = '0; dec_rs1_en = 1'b0; dec_rs2 = '0;
    dec_rs2_en = 1'b0; dec_rd = '0; dec_wr = 1'b0; dec_load = 1'b0; dec_halt = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] main vector table");
    foreach (main_tbl[i]) runVec(main_tbl[i]);
    $display("[TB] reset and drain sequences");
    foreach (rst_tbl[i]) runVec(rst_tbl[i]);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
